// File: rtl/mdu_ctrl_pkg.sv
// Shared multiply/divide definitions: op encodings, default latencies, FSM states
// and the signed divide helper used by the HI/LO sequencer.
package mdu_ctrl_pkg;

    typedef enum logic [3:0] {
        MD_NONE  = 4'd0,
        MD_MULT  = 4'd1,
        MD_MULTU = 4'd2,
        MD_DIV   = 4'd3,
        MD_DIVU  = 4'd4,
        MD_MFHI  = 4'd5,
        MD_MFLO  = 4'd6,
        MD_MTHI  = 4'd7,
        MD_MTLO  = 4'd8
    } mdOp_e;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic {
        S_IDLE,
        S_RUN
    } mduState_e;

    function automatic logic isArith(input logic [3:0] op);
        return (op >= MD_MULT) && (op <= MD_DIVU);
    endfunction

    // Returns {remainder, quotient}. 0x80000000 / -1 is pinned explicitly so the
    // result does not depend on how the tool handles signed overflow.
    function automatic logic [63:0] signedDivRem(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] q;
        logic signed [31:0] r;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'sh8000_0000;
            r = 32'sd0;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage <-> multiply/divide unit bundle: op and operands in; start/busy,
// move-from result and committed HI/LO out.
interface mdu_ctrl_if;
    import mdu_ctrl_pkg::*;

    logic [3:0]  mdOp;
    logic [31:0] rsVal;
    logic [31:0] rtVal;
    logic        start;
    logic        busy;
    logic [31:0] mdOut;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output mdOp, rsVal, rtVal,
        input  start, busy, mdOut, hi, lo
    );

    modport slave (
        input  mdOp, rsVal, rtVal,
        output start, busy, mdOut, hi, lo
    );

endinterface

// File: rtl/mdu_ctrl.sv
// Multiply/divide sequencer with HI/LO register file. The result is computed at
// issue and held in hiTmp/loTmp until the modelled latency expires.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       reset,
    mdu_ctrl_if.slave  bus
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    mduState_e         state;
    logic [CNT_W-1:0]  cnt;
    logic              busyReg;
    logic [31:0]       hiReg;
    logic [31:0]       loReg;
    logic [31:0]       hiTmp;
    logic [31:0]       loTmp;

    logic signed [63:0] prodS;
    logic        [63:0] prodU;
    logic        [63:0] divS;
    logic        [31:0] hiNext;
    logic        [31:0] loNext;
    logic               startInt;

    assign startInt  = isArith(bus.mdOp) && !busyReg;
    assign bus.start = startInt;
    assign bus.busy  = busyReg;
    assign bus.hi    = hiReg;
    assign bus.lo    = loReg;

    always_comb begin
        case (bus.mdOp)
            MD_MFHI: bus.mdOut = hiReg;
            MD_MFLO: bus.mdOut = loReg;
            default: bus.mdOut = 32'd0;
        endcase
    end

    // A zero divisor falls through with the current HI/LO so the commit is a no-op.
    always_comb begin
        hiNext = hiReg;
        loNext = loReg;
        prodS  = $signed({{32{bus.rsVal[31]}}, bus.rsVal}) * $signed({{32{bus.rtVal[31]}}, bus.rtVal});
        prodU  = {32'd0, bus.rsVal} * {32'd0, bus.rtVal};
        divS   = signedDivRem(bus.rsVal, bus.rtVal);
        case (bus.mdOp)
            MD_MULT:  {hiNext, loNext} = prodS;
            MD_MULTU: {hiNext, loNext} = prodU;
            MD_DIV: begin
                if (bus.rtVal != 32'd0) begin
                    {hiNext, loNext} = divS;
                end
            end
            MD_DIVU: begin
                if (bus.rtVal != 32'd0) begin
                    loNext = bus.rsVal / bus.rtVal;
                    hiNext = bus.rsVal % bus.rtVal;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            busyReg <= 1'b0;
            hiReg   <= 32'd0;
            loReg   <= 32'd0;
            hiTmp   <= 32'd0;
            loTmp   <= 32'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (startInt) begin
                        hiTmp   <= hiNext;
                        loTmp   <= loNext;
                        cnt     <= (bus.mdOp == MD_MULT || bus.mdOp == MD_MULTU) ? MULT_LOAD : DIV_LOAD;
                        busyReg <= 1'b1;
                        state   <= S_RUN;
                    end else if (bus.mdOp == MD_MTHI) begin
                        hiReg <= bus.rsVal;
                    end else if (bus.mdOp == MD_MTLO) begin
                        loReg <= bus.rsVal;
                    end
                end
                // Every op except mfhi/mflo is dropped here; the hazard unit should never send one.
                S_RUN: begin
                    cnt <= cnt - CNT_ONE;
                    if (cnt == CNT_ONE) begin
                        hiReg   <= hiTmp;
                        loReg   <= loTmp;
                        busyReg <= 1'b0;
                        state   <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
